// File: rtl/cordic_ctrl_pkg.sv
// cordic_ctrl_pkg: state encoding and operand-mux select codes for the CORDIC sequencer
package cordic_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ITER  = 3'd2,
        SCALE = 3'd3,
        DONE  = 3'd4
    } state_e;

    localparam logic [1:0] SEL_INPUT = 2'b00;
    localparam logic [1:0] SEL_ITER  = 2'b01;
    localparam logic [1:0] SEL_SCALE = 2'b10;

    // SCALE and DONE both present the scale-corrected value to the muxes
    function automatic logic [1:0] sel_of(state_e s);
        return (s == ITER) ? SEL_ITER : (s == SCALE || s == DONE) ? SEL_SCALE : SEL_INPUT;
    endfunction

endpackage

// File: rtl/cordic_mux_sel_fsm_if.sv
// cordic_mux_sel_fsm_if: host handshake plus operand-mux control bundle
interface cordic_mux_sel_fsm_if #(parameter int CNT_W = 5);

    logic             beg_fsm_cordic;
    logic             ack_cordic;
    logic             abort_cordic;
    logic [1:0]       mux_sel;
    logic             enab_reg_xyz;
    logic [CNT_W-1:0] iter_cnt;
    logic             busy_cordic;
    logic             ready_cordic;

    modport master (
        output beg_fsm_cordic, ack_cordic, abort_cordic,
        input  mux_sel, enab_reg_xyz, iter_cnt, busy_cordic, ready_cordic
    );

    modport slave (
        input  beg_fsm_cordic, ack_cordic, abort_cordic,
        output mux_sel, enab_reg_xyz, iter_cnt, busy_cordic, ready_cordic
    );

endinterface

// File: rtl/cordic_iter_counter.sv
// cordic_iter_counter: clearable iteration index that saturates at ITERATIONS-1 and flags it
module cordic_iter_counter #(
    parameter int ITERATIONS = 25,
    parameter int CNT_W      = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    if (ITERATIONS < 1 || (2 ** CNT_W) < ITERATIONS) begin : g_cfg_err
        $error("cordic_iter_counter: CNT_W=%0d cannot index ITERATIONS=%0d", CNT_W, ITERATIONS);
    end

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign cnt = cnt_q;
    assign tc  = (cnt_q == CNT_W'(ITERATIONS - 1));

    // clear wins; increment stops at the terminal count so the index never wraps
    always_comb begin
        cnt_d = clr ? '0 : (en && !tc) ? cnt_q + 1'b1 : cnt_q;
    end

    // index register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/cordic_mux_sel_fsm.sv
// cordic_mux_sel_fsm: sequences the X/Y/Z operand mux select, register load enable and
// iteration index for one CORDIC operation. Optional abort path: CORDIC_ABORT_EN.
module cordic_mux_sel_fsm #(
    parameter int ITERATIONS = 25,
    parameter int CNT_W      = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cordic_mux_sel_fsm_if.slave  bus
);

    import cordic_ctrl_pkg::*;

    state_e state_q, state_d;
    logic   cnt_tc;

    // index is zeroed on entry to LOAD and advances once per ITER cycle
    cordic_iter_counter #(.ITERATIONS(ITERATIONS), .CNT_W(CNT_W)) u_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (state_d == LOAD),
        .en   (state_q == ITER),
        .cnt  (bus.iter_cnt),
        .tc   (cnt_tc)
    );

    // next-state: start only from IDLE, ack only from DONE, abort (if built) overrides in busy states
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.beg_fsm_cordic) state_d = LOAD;
            LOAD:    state_d = ITER;
            ITER:    if (cnt_tc) state_d = SCALE;
            SCALE:   state_d = DONE;
            DONE:    if (bus.ack_cordic) state_d = IDLE;
            default: state_d = IDLE;
        endcase
`ifdef CORDIC_ABORT_EN
        if (bus.abort_cordic && (state_q == LOAD || state_q == ITER || state_q == SCALE))
            state_d = IDLE;
`endif
    end

`ifndef CORDIC_ABORT_EN
    logic unused_abort;
    assign unused_abort = bus.abort_cordic;
`endif

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Moore decode from registered state only
    always_comb begin
        bus.mux_sel      = sel_of(state_q);
        bus.enab_reg_xyz = (state_q == LOAD || state_q == ITER || state_q == SCALE);
        bus.busy_cordic  = (state_q == LOAD || state_q == ITER || state_q == SCALE);
        bus.ready_cordic = (state_q == DONE);
    end

endmodule

// File: tb/tb_cordic_mux_sel_fsm.sv
// tb_cordic_mux_sel_fsm: directed + randomized checks against a step-index reference model
module tb_cordic_mux_sel_fsm;

    localparam int N = 25;
    localparam int W = 5;
`ifdef CORDIC_ABORT_EN
    localparam bit AB = 1'b1;
`else
    localparam bit AB = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errs   = 0;
    int   checks = 0;
    // model: -1 idle, 0 load, 1..N iteration step, N+1 scale, N+2 done
    int   step   = -1;
    int   lat;
    bit   rdy_seen;

    cordic_mux_sel_fsm_if #(.CNT_W(W)) bus ();

    cordic_mux_sel_fsm #(.ITERATIONS(N), .CNT_W(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [1:0] es;
        es = (step <= 0) ? 2'd0 : (step <= N) ? 2'd1 : 2'd2;
        chk({tag, "/sel"},   32'(bus.mux_sel),      32'(es));
        chk({tag, "/en"},    32'(bus.enab_reg_xyz), 32'(step >= 0 && step <= N + 1));
        chk({tag, "/busy"},  32'(bus.busy_cordic),  32'(step >= 0 && step <= N + 1));
        chk({tag, "/ready"}, 32'(bus.ready_cordic), 32'(step == N + 2));
        if (step >= 0 && step <= N + 1)
            chk({tag, "/cnt"}, 32'(bus.iter_cnt),
                (step == 0) ? 32'd0 : (step <= N) ? 32'(step - 1) : 32'(N - 1));
    endtask

    task automatic cyc(input bit b, input bit a, input bit ab, input string tag);
        @(negedge clk);
        bus.beg_fsm_cordic = b;
        bus.ack_cordic     = a;
        bus.abort_cordic   = ab;
        @(posedge clk);
        if (step < 0) begin
            if (b) step = 0;
        end else if (step == N + 2) begin
            if (a) step = -1;
        end else if (AB && ab) begin
            step = -1;
        end else begin
            step++;
        end
        #1 check_model(tag);
    endtask

    task automatic finish_op();
        while (step >= 0 && step < N + 2) cyc(1'b0, 1'b0, 1'b0, "drain");
        if (step == N + 2) cyc(1'b0, 1'b1, 1'b0, "drain_ack");
    endtask

    initial begin
        bus.beg_fsm_cordic = 1'b0;
        bus.ack_cordic     = 1'b0;
        bus.abort_cordic   = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_model("reset");
        chk("reset/cnt", 32'(bus.iter_cnt), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (5) cyc(1'b0, 1'($urandom), 1'($urandom), "idle_noise");

        cyc(1'b1, 1'b0, 1'b0, "start");
        lat = 0;
        for (int i = 2; i <= N + 6 && lat == 0; i++) begin
            cyc(1'b0, 1'b0, 1'b0, "nominal");
            if (bus.ready_cordic === 1'b1) lat = i;
        end
        chk("latency", 32'(lat), 32'(N + 3));

        repeat (10) cyc(1'($urandom), 1'b0, 1'($urandom), "stall");
        cyc(1'b0, 1'b1, 1'b0, "ack");

        cyc(1'b0, 1'b1, 1'b0, "ack_idle");
        cyc(1'b1, 1'b0, 1'b0, "start2");
        while (step <= N + 1) cyc(1'($urandom), 1'($urandom), 1'b0, "beg_in_iter");

        cyc(1'b1, 1'b1, 1'b0, "beg_ack");
        cyc(1'b1, 1'b0, 1'b0, "held_beg");
        finish_op();

        cyc(1'b1, 1'b0, 1'b0, "start_ab");
        while (step != 13) cyc(1'b0, 1'b0, 1'b0, "to12");
        chk("abort/cnt12", 32'(bus.iter_cnt), 32'd12);
        cyc(1'b0, 1'b0, 1'b1, "abort");
        rdy_seen = 1'b0;
        repeat (N + 4) begin
            cyc(1'b0, 1'b0, 1'b0, "post_abort");
            rdy_seen |= (bus.ready_cordic === 1'b1);
        end
        chk("abort/ready_seen", 32'(rdy_seen), 32'(!AB));
        finish_op();

        repeat (400)
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 29) == 0, "random");

        finish_op();
        cyc(1'b1, 1'b0, 1'b0, "start_rst");
        while (step != 8) cyc(1'b0, 1'b0, 1'b0, "to7");
        chk("rst/cnt7", 32'(bus.iter_cnt), 32'd7);
        @(negedge clk);
        #2 rst_n = 1'b0;
        step = -1;
        #1 check_model("async_rst");
        chk("async_rst/cnt", 32'(bus.iter_cnt), 32'd0);
        @(posedge clk);
        #1 check_model("rst_hold");
        @(negedge clk) rst_n = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, "post_rst");
        cyc(1'b1, 1'b0, 1'b0, "restart");
        finish_op();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
